// File: rtl/sprite_array_renderer.sv
// Multi-sprite pixel generator: walks every active sprite slot and emits one
// pixel per cycle (x, y, colour, plot) for a shared bitmap, with clipping at the coordinate edge.
module sprite_array_renderer #(
  parameter int N_SPR   = 10,
  parameter int SPR_W   = 5,
  parameter int SPR_H   = 5,
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SPR*COORD_W-1:0]   x_in,
  input  logic [N_SPR*COORD_W-1:0]   y_in,
  input  logic [N_SPR-1:0]           active_in,
  input  logic                       load_coord,
  input  logic [SPR_W*SPR_H-1:0]     shape,
  input  logic [COLOR_W-1:0]         fg_color,
  input  logic [COLOR_W-1:0]         bg_color,
  input  logic [1:0]                 op,
  input  logic                       start,
  output logic [COORD_W-1:0]         x_out,
  output logic [COORD_W-1:0]         y_out,
  output logic [COLOR_W-1:0]         color_out,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(N_SPR);
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);
  localparam int PIX   = SPR_W * SPR_H;
  localparam int BIT_W = $clog2(PIX);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAW, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;

  logic [COORD_W-1:0] x_q [N_SPR];
  logic [COORD_W-1:0] y_q [N_SPR];
  logic               active_q [N_SPR];

  logic [1:0]         op_q;
  logic [PIX-1:0]     shape_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;

  logic [COORD_W-1:0] x_last_q;
  logic [COORD_W-1:0] y_last_q;
  logic [COLOR_W-1:0] color_last_q;

  logic               load_en;
  logic               frame_go;
  logic               in_draw;
  logic [COORD_W:0]   sum_x;
  logic [COORD_W:0]   sum_y;
  logic [BIT_W-1:0]   bit_idx;
  logic               pix_bit;
  logic               clip;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_plot;

  assign load_en  = (state_q == S_IDLE) && load_coord;
  assign frame_go = (state_q == S_IDLE) && start;
  assign in_draw  = (state_q == S_DRAW);

  // Coordinates only move in IDLE, so a frame always sees a stable set.
  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_q[gi]      <= '0;
        y_q[gi]      <= '0;
        active_q[gi] <= 1'b0;
      end else if (load_en) begin
        x_q[gi]      <= x_in[gi*COORD_W +: COORD_W];
        y_q[gi]      <= y_in[gi*COORD_W +: COORD_W];
        active_q[gi] <= active_in[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= 2'b00;
      shape_q <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
    end else if (frame_go) begin
      op_q    <= op;
      shape_q <= shape;
      fg_q    <= fg_color;
      bg_q    <= bg_color;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (active_q[idx_q]) begin
          state_d = S_DRAW;
          col_d   = '0;
          row_d   = '0;
        end else if (idx_q == IDX_W'(N_SPR - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAW: begin
        if (col_q == COL_W'(SPR_W - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(SPR_H - 1)) begin
            row_d = '0;
            if (idx_q == IDX_W'(N_SPR - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_SCAN;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One spare bit on each sum marks pixels that wrap past the coordinate range.
  assign sum_x   = {1'b0, x_q[idx_q]} + (COORD_W+1)'(col_q);
  assign sum_y   = {1'b0, y_q[idx_q]} + (COORD_W+1)'(row_q);
  assign clip    = sum_x[COORD_W] | sum_y[COORD_W];
  assign bit_idx = BIT_W'(row_q) * BIT_W'(SPR_W) + BIT_W'(col_q);
  assign pix_bit = shape_q[bit_idx];

  always_comb begin
    pix_color = pix_bit ? fg_q : bg_q;
    pix_plot  = 1'b1;
    case (op_q)
      2'b01: pix_color = bg_q;
      2'b10: begin
        pix_color = fg_q;
        pix_plot  = pix_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_last_q     <= '0;
      y_last_q     <= '0;
      color_last_q <= '0;
    end else if (in_draw) begin
      x_last_q     <= sum_x[COORD_W-1:0];
      y_last_q     <= sum_y[COORD_W-1:0];
      color_last_q <= pix_color;
    end
  end

  assign x_out     = in_draw ? sum_x[COORD_W-1:0] : x_last_q;
  assign y_out     = in_draw ? sum_y[COORD_W-1:0] : y_last_q;
  assign color_out = in_draw ? pix_color : color_last_q;
  assign plot      = in_draw & pix_plot & ~clip;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_array_renderer.sv
// Directed bench: default-size renderer across draw/transparent/erase/disturb/reset,
// plus a small-geometry instance checked cycle-by-cycle against a raster model.
module tb_sprite_array_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [79:0] x_in = '0;
  logic [79:0] y_in = '0;
  logic [9:0]  active_in = '0;
  logic        load_coord = 1'b0;
  logic [24:0] shape = '0;
  logic [2:0]  fg_color = '0;
  logic [2:0]  bg_color = '0;
  logic [1:0]  op = 2'b00;
  logic        start = 1'b0;
  logic [7:0]  x_out, y_out;
  logic [2:0]  color_out;
  logic        plot, busy, done;

  logic [35:0] s_x_in = '0;
  logic [35:0] s_y_in = '0;
  logic [3:0]  s_active = '0;
  logic        s_load = 1'b0;
  logic [23:0] s_shape = '0;
  logic        s_start = 1'b0;
  logic [8:0]  s_x_out, s_y_out;
  logic [2:0]  s_color;
  logic        s_plot, s_busy, s_done;

  always #5 clk = ~clk;

  sprite_array_renderer u_dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .active_in(active_in),
    .load_coord(load_coord), .shape(shape), .fg_color(fg_color), .bg_color(bg_color),
    .op(op), .start(start), .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .plot(plot), .busy(busy), .done(done)
  );

  sprite_array_renderer #(.N_SPR(4), .SPR_W(8), .SPR_H(3), .COORD_W(9), .COLOR_W(3)) u_dut2 (
    .clk(clk), .reset(reset), .x_in(s_x_in), .y_in(s_y_in), .active_in(s_active),
    .load_coord(s_load), .shape(s_shape), .fg_color(3'd6), .bg_color(3'd1),
    .op(2'b00), .start(s_start), .x_out(s_x_out), .y_out(s_y_out), .color_out(s_color),
    .plot(s_plot), .busy(s_busy), .done(s_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx [0:511];
  logic [7:0] ry [0:511];
  logic [2:0] rc [0:511];
  logic       rp [0:511];
  int done_n, plots, busy_lo, done_seen;

  logic       e_plot [0:127];
  logic [8:0] e_x [0:127];
  logic [8:0] e_y [0:127];
  logic [2:0] e_c [0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raises start, then records every cycle until done or the budget runs out.
  task automatic run_frame(input int budget, input int disturb);
    start = 1'b1;
    done_n = 0; plots = 0; busy_lo = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; load_coord = 1'b0; end
      if (disturb > 0 && n == disturb) begin
        start = 1'b1; load_coord = 1'b1; x_in = '1; active_in = '1;
      end
      if (disturb > 0 && n == disturb + 1) begin start = 1'b0; load_coord = 1'b0; end
      rx[n] = x_out; ry[n] = y_out; rc[n] = color_out; rp[n] = plot;
      if (plot) plots++;
      if (!busy) busy_lo++;
      if (done) begin done_n = n; break; end
    end
    $display("frame: done at cycle %0d, %0d plots", done_n, plots);
  endtask

  task automatic set_row_coords();
    for (int i = 0; i < 10; i++) begin
      x_in[i*8 +: 8] = 8'(10 * i);
      y_in[i*8 +: 8] = 8'd20;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_x", 32'(x_out), 0);
    check("rst_plot_busy_done", 32'({plot, busy, done}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Full draw, every slot active, plus-shaped bitmap
    set_row_coords();
    active_in = '1;
    shape = {5'b00100, 5'b00100, 5'b11111, 5'b00100, 5'b00100};
    fg_color = 3'd5; bg_color = 3'd2; op = 2'b00; load_coord = 1'b1;
    run_frame(300, 0);
    check("draw_done_cycle", 32'(done_n), 261);
    check("draw_plots", 32'(plots), 250);
    check("draw_busy", 32'(busy_lo), 0);
    check("draw_s3p0_xy", 32'({rx[80], ry[80]}), 32'({8'd30, 8'd20}));
    check("draw_s3p0_col", 32'({rp[80], rc[80]}), 32'({1'b1, 3'd2}));
    check("draw_s3p7", 32'({rx[87], ry[87], rc[87]}), 32'({8'd32, 8'd21, 3'd5}));
    check("draw_s9last", 32'({rx[260], ry[260], rc[260]}), 32'({8'd94, 8'd24, 3'd2}));
    @(negedge clk);
    check("draw_after_hold", 32'({x_out, y_out, plot, busy, done}), 32'({8'd94, 8'd24, 3'b000}));

    // Transparent mode, slots 0 and 2; load and start in the same cycle
    active_in = 10'b0000000101; op = 2'b10; load_coord = 1'b1;
    run_frame(100, 0);
    check("trans_done_cycle", 32'(done_n), 61);
    check("trans_plots", 32'(plots), 18);
    check("trans_clear_px", 32'({rp[2], rc[2]}), 32'({1'b0, 3'd5}));
    check("trans_s0_center", 32'({rp[14], rx[14], ry[14]}), 32'({1'b1, 8'd2, 8'd22}));
    check("trans_s2_px", 32'({rp[31], rx[31], ry[31]}), 32'({1'b1, 8'd22, 8'd20}));
    @(negedge clk);

    // Erase with slot 0 straddling the right edge
    x_in[7:0] = 8'd253; y_in[7:0] = 8'd0; active_in = 10'b1; op = 2'b01; load_coord = 1'b1;
    run_frame(100, 0);
    check("erase_done_cycle", 32'(done_n), 36);
    check("erase_plots", 32'(plots), 15);
    check("erase_x253", 32'({rx[2], rp[2], rc[2]}), 32'({8'd253, 1'b1, 3'd2}));
    check("erase_x255", 32'({rx[4], rp[4], rc[4]}), 32'({8'd255, 1'b1, 3'd2}));
    check("erase_clip0", 32'({rx[5], rp[5]}), 32'({8'd0, 1'b0}));
    check("erase_clip1", 32'({rx[6], rp[6]}), 32'({8'd1, 1'b0}));
    check("erase_row1", 32'({rx[7], ry[7], rp[7]}), 32'({8'd253, 8'd1, 1'b1}));
    @(negedge clk);

    // start/load_coord pulsed mid-frame must not disturb the transparent frame
    set_row_coords();
    active_in = 10'b0000000101; op = 2'b10; load_coord = 1'b1;
    run_frame(100, 20);
    check("dist_done_cycle", 32'(done_n), 61);
    check("dist_plots", 32'(plots), 18);
    check("dist_s2_px", 32'({rp[31], rx[31], ry[31]}), 32'({1'b1, 8'd22, 8'd20}));
    @(negedge clk);

    // Reset in the middle of DRAW
    op = 2'b00; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    check("pre_rst_draw", 32'({plot, x_out, y_out}), 32'({1'b1, 8'd3, 8'd21}));
    reset = 1'b1;
    #1;
    check("midrst_xyc", 32'({x_out, y_out, color_out}), 0);
    check("midrst_flags", 32'({plot, busy, done}), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 0);
    run_frame(30, 0);
    check("postrst_done_cycle", 32'(done_n), 11);
    check("postrst_plots", 32'(plots), 0);
    check("postrst_busy", 32'(busy_lo), 0);
    @(negedge clk);

    // Small-geometry instance against a per-cycle raster model
    s_x_in = {9'd508, 9'd200, 9'd150, 9'd100};
    s_y_in = {9'd10, 9'd9, 9'd8, 9'd7};
    s_active = 4'b1011;
    s_shape = 24'hA53CF0;
    for (int i = 0; i < 128; i++) begin
      e_plot[i] = 1'b0; e_x[i] = '0; e_y[i] = '0; e_c[i] = '0;
    end
    begin
      int n;
      logic [9:0] sx, sy;
      n = 1;
      for (int s = 0; s < 4; s++) begin
        n++;
        if (s_active[s]) begin
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) begin
              sx = {1'b0, s_x_in[s*9 +: 9]} + 10'(c);
              sy = {1'b0, s_y_in[s*9 +: 9]} + 10'(r);
              e_plot[n] = !(sx[9] || sy[9]);
              e_x[n] = sx[8:0];
              e_y[n] = sy[8:0];
              e_c[n] = s_shape[r*8 + c] ? 3'd6 : 3'd1;
              n++;
            end
          end
        end
      end
      check("sweep_model_len", 32'(n), 77);
      s_load = 1'b1; s_start = 1'b1;
      done_n = 0;
      for (int m = 1; m <= 120; m++) begin
        @(negedge clk);
        if (m == 1) begin s_load = 1'b0; s_start = 1'b0; end
        if (s_done) begin done_n = m; break; end
        check("sweep_plot", 32'(s_plot), 32'(e_plot[m]));
        if (e_plot[m])
          check("sweep_pix", 32'({s_x_out, s_y_out, s_color}), 32'({e_x[m], e_y[m], e_c[m]}));
      end
      $display("sweep frame: done at cycle %0d", done_n);
      check("sweep_done_cycle", 32'(done_n), 32'(n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
